// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a five-stage RV32 pipeline: load-use bubbles,
// taken-branch flushes, fixed-latency multi-cycle EX holds and a stall counter.
module pipeline_hazard_controller #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             lu;
    logic             holding;

    assign lu = ex_MemRead && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Hold cycles are MC_WAIT with a nonzero count; mc_cnt==0 is the release cycle.
    assign holding = (state_q == MC_WAIT) && (mc_cnt_q != 8'd0);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_busy      = 1'b0;
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            state_d     = RUN;
            mc_cnt_d    = 8'd0;
        end else if (holding) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            mc_busy      = 1'b1;
            mc_cnt_d     = mc_cnt_q - 8'd1;
        end else begin
            // RUN or release cycle: a release never starts a new multi-cycle op.
            state_d = RUN;
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (ex_mc_start && (state_q == RUN)) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
                mc_busy      = 1'b1;
                mc_cnt_d     = 8'(MC_LATENCY - 2);
                state_d      = MC_WAIT;
            end else if (lu) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            mc_cnt_q      <= 8'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mc_cnt_q      <= mc_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
